// File: rtl/dsec_stream_ingress.sv
// dsec_stream_ingress
//   Ingress stage for the DSEC core. Packs an IN_W-bit beat stream MSB-first
//   into WORD_W-bit words. In key mode KEY_WORDS words build the key register;
//   in data mode words are queued in a FIFO that the core drains.
// Ports
//   clk, rst             clock, synchronous active-high reset
//   key_config           1 = beats are key material, 0 = data
//   in_valid, data_in    input beat
//   flush                zero-pad and push the partial data word
//   rdy                  beat/flush can be accepted (FIFO not full)
//   key_out, key_valid   assembled key (first word in MSBs) and its valid flag
//   word_out, word_last  FIFO head and its "produced by flush" flag
//   word_valid, word_rcvd FIFO not empty / head consumed by core
//   fill                 FIFO occupancy
//   error                sticky protocol/overflow error
module dsec_stream_ingress #(
    parameter int unsigned IN_W       = 8,
    parameter int unsigned WORD_W     = 64,
    parameter int unsigned KEY_WORDS  = 3,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_config,
    input  logic                          in_valid,
    input  logic [IN_W-1:0]               data_in,
    input  logic                          flush,
    output logic                          rdy,
    output logic [KEY_WORDS*WORD_W-1:0]   key_out,
    output logic                          key_valid,
    output logic [WORD_W-1:0]             word_out,
    output logic                          word_last,
    output logic                          word_valid,
    input  logic                          word_rcvd,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          error
);
    localparam int unsigned BEATS = WORD_W / IN_W;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned KW    = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned FW    = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_KEY, S_DATA} state_t;

    state_t                       state_q, state_d;
    logic [BW-1:0]                b_q, b_d, b_cur;
    logic [KW-1:0]                k_q, k_d, k_cur;
    logic [WORD_W-1:0]            acc_q, acc_d, pack_w;
    logic [KEY_WORDS*WORD_W-1:0]  key_q, key_d;
    logic                         key_valid_q, key_valid_d;
    logic                         err_q, err_d;
    logic                         kc_q;
    logic [WORD_W-1:0]            mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]        last_q;
    logic [AW-1:0]                wr_q, rd_q;
    logic [FW-1:0]                fill_q;

    logic                         enter_key, beat_ok, flush_ok, complete;
    logic                         push, push_last, pop;
    logic [WORD_W-1:0]            push_word;

    assign rdy        = (fill_q < FW'(FIFO_DEPTH));
    assign word_valid = (fill_q != '0);
    assign pop        = word_rcvd && word_valid;
    assign word_out   = mem_q[rd_q];
    assign word_last  = last_q[rd_q];
    assign fill       = fill_q;
    assign key_out    = key_q;
    assign key_valid  = key_valid_q;
    assign error      = err_q;

    always_comb begin
        state_d     = state_q;
        b_d         = b_q;
        k_d         = k_q;
        acc_d       = acc_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        err_d       = err_q;
        push        = 1'b0;
        push_last   = 1'b0;
        push_word   = acc_q;

        // From DATA only a rising key_config restarts key loading, so a
        // key_config still high after the last key beat does not re-enter KEY.
        enter_key = ((state_q == S_IDLE) && key_config) ||
                    ((state_q == S_DATA) && key_config && !kc_q);
        b_cur     = enter_key ? '0 : b_q;
        k_cur     = enter_key ? '0 : k_q;
        beat_ok   = in_valid && rdy;
        flush_ok  = flush && rdy;

        // Starting a word clears the accumulator so flushed LSBs are zero.
        pack_w = (b_cur == '0) ? '0 : acc_q;
        pack_w[(BEATS - 1 - int'(b_cur)) * IN_W +: IN_W] = data_in;
        complete = (b_cur == BW'(BEATS - 1));

        if (enter_key) begin
            state_d     = S_KEY;
            key_valid_d = 1'b0;
            err_d       = 1'b0;
            b_d         = '0;
            k_d         = '0;
        end

        if ((state_q == S_KEY) && !key_config) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            b_d     = '0;
            k_d     = '0;
        end else if (enter_key || (state_q == S_KEY)) begin
            if (beat_ok) begin
                acc_d = pack_w;
                if (complete) begin
                    b_d = '0;
                    key_d[(KEY_WORDS - 1 - int'(k_cur)) * WORD_W +: WORD_W] = pack_w;
                    if (k_cur == KW'(KEY_WORDS - 1)) begin
                        key_valid_d = 1'b1;
                        state_d     = S_DATA;
                        k_d         = '0;
                    end else begin
                        k_d = k_cur + 1'b1;
                    end
                end else begin
                    b_d = b_cur + 1'b1;
                end
            end
        end else if (state_q == S_DATA) begin
            if (beat_ok) begin
                acc_d = pack_w;
                // Beat is packed first; a same-cycle flush marks the result last.
                if (complete || flush) begin
                    push      = 1'b1;
                    push_last = flush;
                    push_word = pack_w;
                    b_d       = '0;
                end else begin
                    b_d = b_cur + 1'b1;
                end
            end else if (flush_ok && (b_q != '0)) begin
                push      = 1'b1;
                push_last = 1'b1;
                push_word = acc_q;
                b_d       = '0;
            end
        end else if (beat_ok) begin
            // Data beat in IDLE: no valid key yet.
            err_d = 1'b1;
        end

        if ((in_valid || flush) && !rdy) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            b_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            kc_q        <= 1'b0;
            last_q      <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            fill_q      <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
            kc_q        <= key_config;
            if (push) begin
                mem_q[wr_q]  <= push_word;
                last_q[wr_q] <= push_last;
                wr_q         <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            fill_q <= fill_q + FW'(push) - FW'(pop);
        end
    end
endmodule
